axi_wr_arbiter: RTL and testbench

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

---
 rtl/axi_wr_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI write arbiter.
// One whole write transaction (AW, every W beat, B) is carried per grant.
// Masters are chosen round-robin when both request.
// The slave-side WLAST is regenerated from the latched burst length, and a
// master WLAST that disagrees with it is reported on err_last.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both 1. Valid never waits on ready. Outside the active
// phase the arbiter drives valid and ready to 0 on both sides.
module axi_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                a_clk,
    input  logic                a_resetn,
    // master 0
    input  logic [ID_W-1:0]     m0_aw_id,
    input  logic [ADDR_W-1:0]   m0_aw_addr,
    input  logic [3:0]          m0_aw_len,
    input  logic [2:0]          m0_aw_size,
    input  logic [1:0]          m0_aw_burst,
    input  logic                m0_aw_valid,
    output logic                m0_aw_ready,
    input  logic [DATA_W-1:0]   m0_w_data,
    input  logic [DATA_W/8-1:0] m0_w_strb,
    input  logic                m0_w_last,
    input  logic                m0_w_valid,
    output logic                m0_w_ready,
    output logic [ID_W-1:0]     m0_b_id,
    output logic [1:0]          m0_b_resp,
    output logic                m0_b_valid,
    input  logic                m0_b_ready,
    // master 1
    input  logic [ID_W-1:0]     m1_aw_id,
    input  logic [ADDR_W-1:0]   m1_aw_addr,
    input  logic [3:0]          m1_aw_len,
    input  logic [2:0]          m1_aw_size,
    input  logic [1:0]          m1_aw_burst,
    input  logic                m1_aw_valid,
    output logic                m1_aw_ready,
    input  logic [DATA_W-1:0]   m1_w_data,
    input  logic [DATA_W/8-1:0] m1_w_strb,
    input  logic                m1_w_last,
    input  logic                m1_w_valid,
    output logic                m1_w_ready,
    output logic [ID_W-1:0]     m1_b_id,
    output logic [1:0]          m1_b_resp,
    output logic                m1_b_valid,
    input  logic                m1_b_ready,
    // shared slave
    output logic [ID_W-1:0]     s_aw_id,
    output logic [ADDR_W-1:0]   s_aw_addr,
    output logic [3:0]          s_aw_len,
    output logic [2:0]          s_aw_size,
    output logic [1:0]          s_aw_burst,
    output logic                s_aw_valid,
    input  logic                s_aw_ready,
    output logic [DATA_W-1:0]   s_w_data,
    output logic [DATA_W/8-1:0] s_w_strb,
    output logic                s_w_last,
    output logic                s_w_valid,
    input  logic                s_w_ready,
    input  logic [ID_W-1:0]     s_b_id,
    input  logic [1:0]          s_b_resp,
    input  logic                s_b_valid,
    output logic                s_b_ready,
    // status
    output logic                err_last,
    output logic                grant,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_q;
    logic        grant_q;
    logic        last_grant_q;
    logic [3:0]  len_q;
    logic [3:0]  beat_cnt_q;
    logic        err_last_q;

    logic        grant_d;
    logic        sel_w_last;
    logic        w_last_exp;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;

    assign err_last    = err_last_q;
    assign grant       = grant_q;
    assign dbg_state_o = state_q;

    // Round-robin pick: on contention the master that did not win last time goes next
    always_comb begin
        grant_d = 1'b0;
        if (m0_aw_valid && m1_aw_valid) begin
            grant_d = ~last_grant_q;
        end else if (m1_aw_valid) begin
            grant_d = 1'b1;
        end
    end

    assign sel_w_last = grant_q ? m1_w_last : m0_w_last;
    assign w_last_exp = (beat_cnt_q == len_q);
    assign aw_hs      = s_aw_valid && s_aw_ready;
    assign w_hs       = s_w_valid && s_w_ready;
    assign b_hs       = s_b_valid && s_b_ready;

    // Route only the channel of the current phase, only for the granted master
    always_comb begin
        s_aw_id     = '0;
        s_aw_addr   = '0;
        s_aw_len    = '0;
        s_aw_size   = '0;
        s_aw_burst  = '0;
        s_aw_valid  = 1'b0;
        s_w_data    = '0;
        s_w_strb    = '0;
        s_w_last    = 1'b0;
        s_w_valid   = 1'b0;
        s_b_ready   = 1'b0;
        m0_aw_ready = 1'b0;
        m1_aw_ready = 1'b0;
        m0_w_ready  = 1'b0;
        m1_w_ready  = 1'b0;
        m0_b_id     = '0;
        m0_b_resp   = '0;
        m0_b_valid  = 1'b0;
        m1_b_id     = '0;
        m1_b_resp   = '0;
        m1_b_valid  = 1'b0;
        case (state_q)
            ST_ADDR: begin
                if (grant_q) begin
                    s_aw_id     = m1_aw_id;
                    s_aw_addr   = m1_aw_addr;
                    s_aw_len    = m1_aw_len;
                    s_aw_size   = m1_aw_size;
                    s_aw_burst  = m1_aw_burst;
                    s_aw_valid  = m1_aw_valid;
                    m1_aw_ready = s_aw_ready;
                end else begin
                    s_aw_id     = m0_aw_id;
                    s_aw_addr   = m0_aw_addr;
                    s_aw_len    = m0_aw_len;
                    s_aw_size   = m0_aw_size;
                    s_aw_burst  = m0_aw_burst;
                    s_aw_valid  = m0_aw_valid;
                    m0_aw_ready = s_aw_ready;
                end
            end
            ST_DATA: begin
                // WLAST comes from the beat counter, never from the master
                s_w_last = w_last_exp;
                if (grant_q) begin
                    s_w_data   = m1_w_data;
                    s_w_strb   = m1_w_strb;
                    s_w_valid  = m1_w_valid;
                    m1_w_ready = s_w_ready;
                end else begin
                    s_w_data   = m0_w_data;
                    s_w_strb   = m0_w_strb;
                    s_w_valid  = m0_w_valid;
                    m0_w_ready = s_w_ready;
                end
            end
            ST_RESP: begin
                if (grant_q) begin
                    m1_b_id    = s_b_id;
                    m1_b_resp  = s_b_resp;
                    m1_b_valid = s_b_valid;
                    s_b_ready  = m1_b_ready;
                end else begin
                    m0_b_id    = s_b_id;
                    m0_b_resp  = s_b_resp;
                    m0_b_valid = s_b_valid;
                    s_b_ready  = m0_b_ready;
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM with its registered grant, burst tracking and error pulse
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            len_q        <= 4'd0;
            beat_cnt_q   <= 4'd0;
            err_last_q   <= 1'b0;
        end else begin
            err_last_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (m0_aw_valid || m1_aw_valid) begin
                        grant_q <= grant_d;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (aw_hs) begin
                        len_q      <= s_aw_len;
                        beat_cnt_q <= 4'd0;
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        err_last_q <= (sel_w_last != w_last_exp);
                        // Hold the counter on the final beat so len=15 never wraps
                        if (w_last_exp) begin
                            state_q <= ST_RESP;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (b_hs) begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: two master drivers, a slave responder,
// and a scoreboard that checks AW, W, B and err_last traffic against
// expected queues filled by the test sequence.
module tb_axi_wr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- master-side signals ----------------
    logic [IW-1:0] m_aw_id[2];
    logic [AW-1:0] m_aw_addr[2];
    logic [3:0]    m_aw_len[2];
    logic [2:0]    m_aw_size[2];
    logic [1:0]    m_aw_burst[2];
    logic          m_aw_valid[2];
    logic [DW-1:0] m_w_data[2];
    logic [3:0]    m_w_strb[2];
    logic          m_w_last[2];
    logic          m_w_valid[2];
    logic          m_b_ready[2];

    logic          m0_aw_ready, m1_aw_ready, m0_w_ready, m1_w_ready;
    logic [IW-1:0] m0_b_id, m1_b_id;
    logic [1:0]    m0_b_resp, m1_b_resp;
    logic          m0_b_valid, m1_b_valid;

    // ---------------- slave-side signals ----------------
    logic [IW-1:0] s_aw_id;
    logic [AW-1:0] s_aw_addr;
    logic [3:0]    s_aw_len;
    logic [2:0]    s_aw_size;
    logic [1:0]    s_aw_burst;
    logic          s_aw_valid, s_aw_ready;
    logic [DW-1:0] s_w_data;
    logic [3:0]    s_w_strb;
    logic          s_w_last, s_w_valid, s_w_ready;
    logic [IW-1:0] s_b_id;
    logic [1:0]    s_b_resp;
    logic          s_b_valid, s_b_ready;
    logic          err_last, grant;
    logic [1:0]    dbg_state;

    axi_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .a_clk(clk), .a_resetn(rst_n),
        .m0_aw_id(m_aw_id[0]), .m0_aw_addr(m_aw_addr[0]), .m0_aw_len(m_aw_len[0]),
        .m0_aw_size(m_aw_size[0]), .m0_aw_burst(m_aw_burst[0]), .m0_aw_valid(m_aw_valid[0]),
        .m0_aw_ready(m0_aw_ready),
        .m0_w_data(m_w_data[0]), .m0_w_strb(m_w_strb[0]), .m0_w_last(m_w_last[0]),
        .m0_w_valid(m_w_valid[0]), .m0_w_ready(m0_w_ready),
        .m0_b_id(m0_b_id), .m0_b_resp(m0_b_resp), .m0_b_valid(m0_b_valid), .m0_b_ready(m_b_ready[0]),
        .m1_aw_id(m_aw_id[1]), .m1_aw_addr(m_aw_addr[1]), .m1_aw_len(m_aw_len[1]),
        .m1_aw_size(m_aw_size[1]), .m1_aw_burst(m_aw_burst[1]), .m1_aw_valid(m_aw_valid[1]),
        .m1_aw_ready(m1_aw_ready),
        .m1_w_data(m_w_data[1]), .m1_w_strb(m_w_strb[1]), .m1_w_last(m_w_last[1]),
        .m1_w_valid(m_w_valid[1]), .m1_w_ready(m1_w_ready),
        .m1_b_id(m1_b_id), .m1_b_resp(m1_b_resp), .m1_b_valid(m1_b_valid), .m1_b_ready(m_b_ready[1]),
        .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
        .s_aw_burst(s_aw_burst), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .err_last(err_last), .grant(grant), .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [45:0] exp_aw_q[$];   // {grant, id, addr, len, size, burst}
    logic [36:0] exp_w_q[$];    // {last, strb, data}
    logic [6:0]  exp_b_q[$];    // {master, id, resp}
    logic [3:0]  exp_err_q[$];  // beat index that carried a bad WLAST
    int   w_hs_total = 0;
    int   beat_idx   = 0;
    int   last_beat  = 0;
    bit   toggle_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_total++;
        $display("FAIL %s: event not expected or not seen in time", name);
    endtask

    function automatic logic [9:0] vr_outputs();
        return {m0_aw_ready, m1_aw_ready, m0_w_ready, m1_w_ready, m0_b_valid,
                m1_b_valid, s_aw_valid, s_w_valid, s_b_ready, err_last};
    endfunction

    function automatic logic get_sig(input int n, input int ch);
        case (ch)
            0:       return (n == 1) ? m1_aw_ready : m0_aw_ready;
            1:       return (n == 1) ? m1_w_ready  : m0_w_ready;
            default: return (n == 1) ? m1_b_valid  : m0_b_valid;
        endcase
    endfunction

    // ---------------- expected-value producer ----------------
    task automatic expect_write(input int n, input logic [3:0] id, input logic [31:0] addr,
                                input logic [3:0] len, input logic [31:0] base,
                                input int nbeats, input bit with_b);
        logic n1;
        n1 = (n == 1);
        exp_aw_q.push_back({n1, id, addr, len, 3'b010, 2'b01});
        for (int i = 0; i < nbeats; i++)
            exp_w_q.push_back({(i == int'(len)), 4'(i), 32'(base + 32'(i))});
        if (with_b) exp_b_q.push_back({n1, id, id[1:0]});
    endtask

    // ---------------- master driver tasks ----------------
    task automatic drop_master(input int n);
        m_aw_valid[n] = 1'b0;
        m_w_valid[n]  = 1'b0;
        m_w_last[n]   = 1'b0;
        m_b_ready[n]  = 1'b0;
    endtask

    // Wait (sampling on falling edges) until the channel signal is high.
    task automatic wait_sig(input int n, input int ch, output bit ok);
        int budget;
        ok = 1'b0;
        budget = 0;
        while (budget < 300) begin
            @(negedge clk);
            if (!rst_n) return;
            if (get_sig(n, ch)) begin
                ok = 1'b1;
                return;
            end
            budget++;
        end
        note_fail($sformatf("m%0d_ch%0d_timeout", n, ch));
    endtask

    task automatic master_write(input int n, input logic [3:0] id, input logic [31:0] addr,
                                input logic [3:0] len, input logic [31:0] base, input int bad_beat);
        bit ok;
        m_aw_id[n]    = id;
        m_aw_addr[n]  = addr;
        m_aw_len[n]   = len;
        m_aw_size[n]  = 3'b010;
        m_aw_burst[n] = 2'b01;
        m_aw_valid[n] = 1'b1;
        wait_sig(n, 0, ok);
        if (!ok) begin drop_master(n); return; end
        @(posedge clk); #1;
        m_aw_valid[n] = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            m_w_data[n]  = 32'(base + 32'(i));
            m_w_strb[n]  = 4'(i);
            m_w_last[n]  = (i == int'(len)) || (i == bad_beat);
            m_w_valid[n] = 1'b1;
            wait_sig(n, 1, ok);
            if (!ok) begin drop_master(n); return; end
            @(posedge clk); #1;
        end
        m_w_valid[n] = 1'b0;
        m_w_last[n]  = 1'b0;
        m_b_ready[n] = 1'b1;
        wait_sig(n, 2, ok);
        if (!ok) begin drop_master(n); return; end
        @(posedge clk); #1;
        m_b_ready[n] = 1'b0;
    endtask

    // ---------------- slave responder ----------------
    initial begin : slave_model
        logic [IW-1:0] slv_id, cap_id;
        bit aw_seen, w_end, b_end;
        s_aw_ready = 1'b1;
        s_w_ready  = 1'b1;
        s_b_valid  = 1'b0;
        s_b_id     = '0;
        s_b_resp   = '0;
        slv_id     = '0;
        forever begin
            @(negedge clk);
            aw_seen = s_aw_valid && s_aw_ready;
            cap_id  = s_aw_id;
            w_end   = s_w_valid && s_w_ready && s_w_last;
            b_end   = s_b_valid && s_b_ready;
            @(posedge clk); #1;
            if (toggle_mode) s_w_ready = ~s_w_ready;
            else s_w_ready = 1'b1;
            if (!rst_n) begin
                s_b_valid = 1'b0;
                continue;
            end
            if (aw_seen) slv_id = cap_id;
            if (b_end) s_b_valid = 1'b0;
            if (w_end) begin
                s_b_valid = 1'b1;
                s_b_id    = slv_id;
                s_b_resp  = slv_id[1:0];
            end
        end
    end

    // ---------------- monitor: pops and compares on every handshake ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            beat_idx = 0;
        end else begin
            if (err_last) begin
                if (exp_err_q.size() == 0) note_fail("unexpected_err_last");
                else check("err_last_beat", 64'(last_beat), 64'(exp_err_q.pop_front()));
            end
            if (s_aw_valid && s_aw_ready) begin
                if (exp_aw_q.size() == 0) note_fail("unexpected_aw");
                else check("aw_fwd", {grant, s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst},
                           exp_aw_q.pop_front());
            end
            if (s_w_valid && s_w_ready) begin
                if (exp_w_q.size() == 0) note_fail("unexpected_w");
                else check("w_fwd", {s_w_last, s_w_strb, s_w_data}, exp_w_q.pop_front());
                w_hs_total++;
                last_beat = beat_idx;
                beat_idx  = s_w_last ? 0 : beat_idx + 1;
            end
            if (m0_b_valid && m_b_ready[0]) begin
                if (exp_b_q.size() == 0) note_fail("unexpected_b_m0");
                else check("b_m0", {1'b0, m0_b_id, m0_b_resp}, exp_b_q.pop_front());
            end
            if (m1_b_valid && m_b_ready[1]) begin
                if (exp_b_q.size() == 0) note_fail("unexpected_b_m1");
                else check("b_m1", {1'b1, m1_b_id, m1_b_resp}, exp_b_q.pop_front());
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_ready", 64'(vr_outputs()), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin : stimulus
        int start, waited, blocked_bad;
        bit m0_done;
        rst_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_aw_id[n] = '0; m_aw_addr[n] = '0; m_aw_len[n] = '0;
            m_aw_size[n] = '0; m_aw_burst[n] = '0; m_w_data[n] = '0; m_w_strb[n] = '0;
            drop_master(n);
        end
        do_reset();

        // single-beat write from m0, with AW latency and IDLE field checks
        check("idle_fields_zero", {s_aw_id, s_aw_addr, s_w_data}, 64'd0);
        expect_write(0, 4'h5, 32'h0000_1000, 4'd0, 32'hA000_0000, 1, 1'b1);
        fork
            master_write(0, 4'h5, 32'h0000_1000, 4'd0, 32'hA000_0000, -1);
            begin
                @(negedge clk);
                check("aw_valid_before_grant", 64'(s_aw_valid), 64'd0);
                @(negedge clk);
                check("aw_valid_latency", 64'(s_aw_valid), 64'd1);
                check("grant_m0", 64'(grant), 64'd0);
            end
        join
        @(negedge clk);
        check("back_to_idle", 64'(dbg_state), 64'd0);

        // both masters from reset, two transactions each: m0, m1, m0, m1
        do_reset();
        expect_write(0, 4'h1, 32'h0000_2000, 4'd1, 32'hB000_0000, 2, 1'b1);
        expect_write(1, 4'h2, 32'h0000_3000, 4'd1, 32'hC000_0000, 2, 1'b1);
        expect_write(0, 4'h3, 32'h0000_2100, 4'd0, 32'hB100_0000, 1, 1'b1);
        expect_write(1, 4'h4, 32'h0000_3100, 4'd2, 32'hC100_0000, 3, 1'b1);
        fork
            begin
                master_write(0, 4'h1, 32'h0000_2000, 4'd1, 32'hB000_0000, -1);
                master_write(0, 4'h3, 32'h0000_2100, 4'd0, 32'hB100_0000, -1);
            end
            begin
                master_write(1, 4'h2, 32'h0000_3000, 4'd1, 32'hC000_0000, -1);
                master_write(1, 4'h4, 32'h0000_3100, 4'd2, 32'hC100_0000, -1);
            end
        join
        repeat (2) @(posedge clk); #1;

        // m1 waits through a full m0 len=3 transaction
        expect_write(0, 4'h7, 32'h0000_4000, 4'd3, 32'hD000_0000, 4, 1'b1);
        expect_write(1, 4'h9, 32'h0000_4100, 4'd1, 32'hD100_0000, 2, 1'b1);
        m0_done = 1'b0;
        blocked_bad = 0;
        fork
            begin
                master_write(0, 4'h7, 32'h0000_4000, 4'd3, 32'hD000_0000, -1);
                m0_done = 1'b1;
            end
            begin
                @(posedge clk); #1;
                master_write(1, 4'h9, 32'h0000_4100, 4'd1, 32'hD100_0000, -1);
            end
            begin
                @(negedge clk);
                while (!m0_done) begin
                    if (m1_aw_ready) blocked_bad++;
                    @(negedge clk);
                end
                check("m1_blocked_during_m0", 64'(blocked_bad), 64'd0);
                check("idle_gap_state", 64'(dbg_state), 64'd0);
                @(negedge clk);
                check("m1_granted_state", 64'(dbg_state), 64'd1);
                check("m1_granted_grant", 64'(grant), 64'd1);
            end
        join
        repeat (2) @(posedge clk); #1;

        // len=2 with the master raising WLAST early on beat 1
        expect_write(0, 4'hA, 32'h0000_5000, 4'd2, 32'hE000_0000, 3, 1'b1);
        exp_err_q.push_back(4'd1);
        master_write(0, 4'hA, 32'h0000_5000, 4'd2, 32'hE000_0000, 1);
        repeat (2) @(posedge clk); #1;

        // len=15 with s_w_ready toggling
        toggle_mode = 1'b1;
        expect_write(1, 4'h3, 32'h0000_6000, 4'd15, 32'h5500_0000, 16, 1'b1);
        master_write(1, 4'h3, 32'h0000_6000, 4'd15, 32'h5500_0000, -1);
        toggle_mode = 1'b0;
        repeat (2) @(posedge clk); #1;

        // reset asserted while beat 2 of an m0 burst is on the bus
        expect_write(0, 4'h6, 32'h0000_7000, 4'd3, 32'hF000_0000, 2, 1'b0);
        start = w_hs_total;
        fork
            master_write(0, 4'h6, 32'h0000_7000, 4'd3, 32'hF000_0000, -1);
            begin
                waited = 0;
                while ((w_hs_total < start + 2) && (waited < 200)) begin
                    @(negedge clk); #1;
                    waited++;
                end
                check("beats_before_reset", 64'(w_hs_total - start), 64'd2);
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                check("mid_rst_valid_ready", 64'(vr_outputs()), 64'd0);
                check("mid_rst_state", 64'(dbg_state), 64'd0);
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        @(posedge clk); #1;
        expect_write(1, 4'hB, 32'h0000_8000, 4'd0, 32'h1234_0000, 1, 1'b1);
        master_write(1, 4'hB, 32'h0000_8000, 4'd0, 32'h1234_0000, -1);

        repeat (5) @(posedge clk); #1;
        check("aw_queue_drained", 64'(exp_aw_q.size()), 64'd0);
        check("w_queue_drained", 64'(exp_w_q.size()), 64'd0);
        check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
        check("err_queue_drained", 64'(exp_err_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
